// File: rtl/add_rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: each stage ripples one WIDTH/STAGES chunk,
// carrying the partial sum, the unprocessed operand chunks and the chunk carry forward.
module add_rca_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int C = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  // Returns {carry into chunk MSB, carry out of chunk, chunk sum}.
  function automatic logic [C+1:0] ripple(input logic [C-1:0] x, input logic [C-1:0] y,
                                          input logic ci);
    logic [C-1:0] s;
    logic         cy;
    logic         c_msb;
    cy    = ci;
    c_msb = ci;
    for (int i = 0; i < C; i++) begin
      c_msb = cy;
      s[i]  = x[i] ^ y[i] ^ cy;
      cy    = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    return {c_msb, cy, s};
  endfunction

  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] sum_p [STAGES];
  logic             cy_p  [STAGES];
  logic             ovf_p [STAGES];
  logic             vld_p [STAGES];
  logic             advance;

  // A single global advance keeps every in-flight set aligned; bubbles move like data.
  assign advance   = out_ready | ~vld_p[L];
  assign in_ready  = advance;
  assign out_valid = vld_p[L];
  assign sum       = sum_p[L];
  assign c_out     = cy_p[L];
  assign ovf       = ovf_p[L];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_nxt;
    logic             ci;
    logic             vin;
    logic [C+1:0]     r;

    if (k == 0) begin : g_first
      // Subtract is a + ~b + ~c_in, so inversion happens once at accept.
      assign a_in   = a;
      assign b_in   = b ^ {WIDTH{sub}};
      assign ci     = c_in ^ sub;
      assign sum_in = '0;
      assign vin    = in_valid;
    end else begin : g_next
      assign a_in   = a_p[k-1];
      assign b_in   = b_p[k-1];
      assign ci     = cy_p[k-1];
      assign sum_in = sum_p[k-1];
      assign vin    = vld_p[k-1];
    end

    assign r = ripple(a_in[k*C +: C], b_in[k*C +: C], ci);

    always_comb begin
      sum_nxt            = sum_in;
      sum_nxt[k*C +: C]  = r[C-1:0];
    end

    // Stage k boundary
    always_ff @(posedge clk) begin
      if (rst)          vld_p[k] <= 1'b0;
      else if (advance) vld_p[k] <= vin;
    end

    if (k == L) begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_p[k] <= '0;
          cy_p[k]  <= 1'b0;
          ovf_p[k] <= 1'b0;
        end else if (advance) begin
          sum_p[k] <= sum_nxt;
          cy_p[k]  <= r[C];
          ovf_p[k] <= r[C+1] ^ r[C];
        end
      end
      always_ff @(posedge clk) begin
        if (advance) begin
          a_p[k] <= a_in;
          b_p[k] <= b_in;
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (advance) begin
          a_p[k]   <= a_in;
          b_p[k]   <= b_in;
          sum_p[k] <= sum_nxt;
          cy_p[k]  <= r[C];
          ovf_p[k] <= r[C+1] ^ r[C];
        end
      end
    end
  end

endmodule

// File: tb/tb_add_rca_pipe.sv
// Bench for add_rca_pipe: directed boundary vectors, backpressured and random streams
// against an integer-arithmetic reference, reset with sets in flight, and STAGES=1.
module tb_add_rca_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        c_in, sub, c_out, ovf;

  logic        s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [15:0] s1_a, s1_b, s1_sum;
  logic        s1_c_in, s1_sub, s1_c_out, s1_ovf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  add_rca_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf)
  );

  add_rca_pipe #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready), .a(s1_a), .b(s1_b),
    .c_in(s1_c_in), .sub(s1_sub), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
    .sum(s1_sum), .c_out(s1_c_out), .ovf(s1_ovf)
  );

  // Reference: plain integer arithmetic. Returns {ovf, c_out, sum}.
  function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                             input logic ci, input logic sb);
    int u, sr;
    logic [15:0] s;
    logic co, ov;
    if (!sb) begin
      u  = int'(x) + int'(y) + int'(ci);
      sr = int'($signed(x)) + int'($signed(y)) + int'(ci);
      co = (u > 65535);
    end else begin
      u  = int'(x) - int'(y) - int'(ci);
      sr = int'($signed(x)) - int'($signed(y)) - int'(ci);
      co = (u >= 0);
    end
    s  = u[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    s1_in_valid = 1'b0; s1_out_ready = 1'b1; s1_a = '0; s1_b = '0; s1_c_in = 1'b0; s1_sub = 1'b0;
    repeat (3) tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ctrl out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    vectors++;
    if ({ovf, c_out, sum} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_data got=%h expected 0", {ovf, c_out, sum});
    end
    vectors++;
    if (s1_out_valid !== 1'b0 || s1_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_s1 out_valid=%b in_ready=%b expected 0/1", s1_out_valid, s1_in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007};
    logic [15:0] tb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'hFFFF, 16'h0007, 16'h0005};
    logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] te [6] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                            {2'b11, 16'h7FFF}, {2'b00, 16'hFFFE}, {2'b01, 16'h0001}};
    int lat;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1;
      in_valid = 1'b1; a = ta[i]; b = tb[i]; c_in = tc[i]; sub = ts[i];
      tick();
      in_valid = 1'b0; a = $urandom(); b = $urandom();
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      vectors++;
      if (lat != 4) begin
        miscompares++;
        $display("FAIL directed_latency[%0d] got=%0d expected 4", i, lat);
      end
      vectors++;
      if ({ovf, c_out, sum} !== te[i]) begin
        miscompares++;
        $display("FAIL directed_result[%0d] got ovf/cout/sum=%h expected %h", i,
                 {ovf, c_out, sum}, te[i]);
      end
      tick();
    end
  endtask

  task automatic test_stream(input int n, input bit rnd);
    logic [17:0] exp_q [$];
    logic [17:0] held, e;
    logic [15:0] ca, cb;
    logic        cc, cs;
    bit          was_stall = 0;
    int sent = 0, got = 0, cyc = 0;
    ca = 16'($urandom()); cb = 16'($urandom()); cc = 1'($urandom()); cs = 1'($urandom());
    while (got < n && cyc < 500) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc < 7);
      in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 4) != 0) : 1'b1);
      a = ca; b = cb; c_in = cc; sub = cs;
      #1;
      if (was_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || {ovf, c_out, sum} !== held) begin
          miscompares++;
          $display("FAIL stall_hold out_valid=%b got=%h expected held %h", out_valid,
                   {ovf, c_out, sum}, held);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b0) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_in_ready got=%b expected 0", in_ready);
        end
        held = {ovf, c_out, sum};
        was_stall = 1;
      end else begin
        was_stall = 0;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL stream_extra got=%h expected no result", {ovf, c_out, sum});
        end else begin
          e = exp_q.pop_front();
          if ({ovf, c_out, sum} !== e) begin
            miscompares++;
            $display("FAIL stream_result[%0d] got=%h expected %h", got, {ovf, c_out, sum}, e);
          end
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(ref_model(ca, cb, cc, cs));
        sent++;
        ca = 16'($urandom()); cb = 16'($urandom()); cc = 1'($urandom()); cs = 1'($urandom());
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != n || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_count got=%0d results expected %0d (pending %0d)", got, n,
               exp_q.size());
    end
    repeat (6) tick();
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'($urandom()); b = 16'($urandom()); c_in = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || {ovf, c_out, sum} !== 18'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_inflight out_valid=%b data=%h in_ready=%b expected 0/0/1",
               out_valid, {ovf, c_out, sum}, in_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stale cycle %0d out_valid=%b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_stages1();
    logic [15:0] ta [2] = '{16'h1234, 16'hFFFF};
    logic [15:0] tb [2] = '{16'h4321, 16'h0001};
    logic [17:0] te [2] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}};
    int lat;
    for (int i = 0; i < 2; i++) begin
      s1_out_ready = 1'b1;
      s1_in_valid = 1'b1; s1_a = ta[i]; s1_b = tb[i]; s1_c_in = 1'b0; s1_sub = 1'b0;
      tick();
      s1_in_valid = 1'b0;
      lat = 1;
      while (s1_out_valid !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      vectors++;
      if (lat != 1) begin
        miscompares++;
        $display("FAIL s1_latency[%0d] got=%0d expected 1", i, lat);
      end
      vectors++;
      if ({s1_ovf, s1_c_out, s1_sum} !== te[i]) begin
        miscompares++;
        $display("FAIL s1_result[%0d] got=%h expected %h", i, {s1_ovf, s1_c_out, s1_sum}, te[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(8, 1'b0);
    test_stream(60, 1'b1);
    test_reset_inflight();
    test_stages1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
